spart_rx: RTL
=============

# spart_rx

Serial receiver for the mini-SPART, the line-side counterpart of the transmitter. It uses the shared 16x baud enable to oversample RxD and detects the start bit. It samples eight data bits LSB-first at bit centre and checks the stop bit. The received byte is presented to the bus interface with a ready flag (RDA), a framing error flag and an overrun flag.

## Interface
- OVS, 16: enable ticks per bit. Must be a power of 2 and ≥ 8.
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  baud oversample tick, one clk wide, OVS per bit period
- RxD  input  1  asynchronous serial line; idle level is 1
- clr_rda  input  1  bus read acknowledge, one clk wide
- data  output  8  last received byte (registered)
- rda  output  1  receive data available
- fe  output  1  framing error for the byte currently in `data`
- oe  output  1  overrun: a byte completed while rda was already 1

## Operation
- RxD passes through a 2-flop synchronizer to produce rxd_s. Both flops reset to 1.
- last_bit holds rxd_s as captured on the most recent en tick. It resets to 1.
- Counters:
  - tick counter: log2(OVS) bits, down-counting on en.
  - bit counter: 3 bits.
- States:
  - IDLE
    - A new frame begins on an en tick where rxd_s=0 and last_bit=1, i.e. a falling edge at tick resolution.
    - On that tick: go to START and load the tick counter with OVS/2−1.
    - A line held low never starts a second frame until it returns high.
  - START
    - Count down on each en tick. On the zero-count tick, sample the start bit.
    - Sample 0: go to DATA, load OVS−1, and set the bit counter to 0.
    - Sample 1 (glitch): go to IDLE. No flags change.
  - DATA
    - Count down. On each zero-count tick, shift the sample into the shift register MSB (LSB-first reception) and reload OVS−1.
    - After bit 7 is sampled, go to STOP.
  - STOP
    - On the zero-count tick, sample the stop bit.
    - data ← shift register.
    - fe ← ~sample.
    - If rda=1 and clr_rda=0 in that cycle, oe ← 1.
    - rda ← 1.
    - Go to IDLE.
- Flag updates:
  - clr_rda clears rda and oe.
  - fe is not cleared by clr_rda. It is overwritten at every frame completion.
  - When frame completion and clr_rda occur in the same cycle, completion wins: rda=1 and oe is unchanged.
- Cycles without en do not advance any state or counter.

## Timing
- Reset values: data=8'h00, rda=0, fe=0, oe=0, state IDLE, counters 0, last_bit=1.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is ever delivered.
- Synchronizer latency is 2 clk. Start detection is resolved on the first en tick after rxd_s falls.
- Sample points fall at OVS/2 + k·OVS ticks after start detection, for k = 0..9 (k=0 start bit, k=1..8 data bits, k=9 stop bit).
- data, rda, fe and oe update on the clk edge that ends the stop-sample en cycle. data is stable whenever rda=1.
- A new start can be detected on the en tick immediately after the stop sample, provided last_bit=1.

## Configuration
- SPART_RX_MAJORITY_EN
  - Defined: each bit decision is the 2-of-3 majority of rxd_s at sample tick −1, 0 and +1. The decision is made at tick +1, so every sample point, including the start-bit check, shifts one en tick later, and frame completion moves one tick later.
  - Undefined: a single sample at the nominal tick. No extra registers are present.

## Structure
- spart_pkg holds:
  - state encodings: RX_IDLE, RX_START, RX_DATA, RX_STOP
  - OVS default
  - SPART_DATA_BITS = 8
- One sub-module, spart_rx_sampler. It contains:
  - the 2-flop synchronizer
  - the last_bit register
  - the optional majority-vote history, guarded by SPART_RX_MAJORITY_EN
- spart_rx_sampler outputs rxd_s and the voted bit value.
- spart_rx contains the FSM, the counters, the shift register and the flags.

## Test plan
- Reset: drive rst=0 mid-frame, then release. All outputs are 0, and a frame sent 5 ticks later is received correctly.
- Frame 8'hA5 with stop=1, en every 2 clk: data=8'hA5, rda=1, fe=0 at the stop-sample edge. clr_rda → rda=0.
- Glitch: RxD low for 3 en ticks, then high. rda stays 0 and the block returns to IDLE. A following 8'h5A is received intact.
- Framing error:
  - Send 8'h3C with stop=0: data=8'h3C, rda=1, fe=1.
  - Then hold RxD low for 40 ticks: no further completion.
  - Release and send 8'h01: data=8'h01, fe=0.
- Overrun and collision:
  - Send 8'h11, then 8'h22 with no clr_rda: data=8'h22, oe=1.
  - Pulse clr_rda: rda=0, oe=0.
  - Assert clr_rda in the same clk as the next completion: rda=1.
- Majority (macro defined): a one-tick low pulse at the centre of bit 3 of 8'hFF still yields data=8'hFF. Without the macro the same pulse yields 8'hF7.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the mini-SPART receiver: receiver FSM states and default sizing.
package spart_pkg;

   localparam int unsigned SPART_OVS       = 16;
   localparam int unsigned SPART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/spart_rx_if.sv
// Bus-side view of the receiver: received byte, status flags and the read acknowledge.
interface spart_rx_if;
   import spart_pkg::*;

   logic [SPART_DATA_BITS-1:0] data;
   logic                       rda;
   logic                       fe;
   logic                       oe;
   logic                       clr_rda;

   modport master (output data, output rda, output fe, output oe, input clr_rda);
   modport slave  (input data, input rda, input fe, input oe, output clr_rda);

endinterface

// File: rtl/spart_rx_sampler.sv
// RxD synchronizer, tick-resolution history and bit decision.
// SPART_RX_MAJORITY_EN: decide each bit as the 2-of-3 vote over three consecutive en ticks.
module spart_rx_sampler
   import spart_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic rxd,
   output logic rxd_s,
   output logic last_bit,
   output logic bit_val
);

   logic sync1_q, sync2_q, last_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= 1'b1;
      end else if (en) begin
         last_q <= sync2_q;
      end
   end

`ifdef SPART_RX_MAJORITY_EN
   logic hist_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= 1'b1;
      end else if (en) begin
         hist_q <= last_q;
      end
   end

   // Evaluated on the tick after nominal: hist_q is tick -1, last_q tick 0, sync2_q tick +1.
   assign bit_val = (hist_q & last_q) | (hist_q & sync2_q) | (last_q & sync2_q);
`else
   assign bit_val = sync2_q;
`endif

   assign rxd_s    = sync2_q;
   assign last_bit = last_q;

endmodule

// File: rtl/spart_rx.sv
// mini-SPART serial receiver: start detection, bit-centre sampling, byte delivery and flags.
// SPART_RX_MAJORITY_EN (in spart_rx_sampler) delays every sample point by one en tick.
module spart_rx
   import spart_pkg::*;
#(
   parameter int unsigned OVS = SPART_OVS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       rxd,
   spart_rx_if.master bus
);

   localparam int unsigned CW = $clog2(OVS);
`ifdef SPART_RX_MAJORITY_EN
   localparam logic [CW-1:0] START_LOAD = CW'(OVS / 2);
`else
   localparam logic [CW-1:0] START_LOAD = CW'(OVS / 2 - 1);
`endif
   localparam logic [CW-1:0] BIT_LOAD  = CW'(OVS - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(SPART_DATA_BITS - 1);

   rx_state_e state_q, state_d;

   logic [CW-1:0]              cnt_q, cnt_d;
   logic [2:0]                 bit_cnt_q, bit_cnt_d;
   logic [SPART_DATA_BITS-1:0] shift_q, shift_d;
   logic [SPART_DATA_BITS-1:0] data_q, data_d;
   logic                       rda_q, rda_d;
   logic                       fe_q, fe_d;
   logic                       oe_q, oe_d;
   logic                       complete;

   logic rxd_s, last_bit, bit_val;
   logic start_edge, tick_zero;

   spart_rx_sampler u_sampler (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .rxd      (rxd),
      .rxd_s    (rxd_s),
      .last_bit (last_bit),
      .bit_val  (bit_val)
   );

   assign start_edge = en && !rxd_s && last_bit;
   assign tick_zero  = en && (cnt_q == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RX_IDLE:  if (start_edge) state_d = RX_START;
         RX_START: if (tick_zero) state_d = bit_val ? RX_IDLE : RX_DATA;
         RX_DATA:  if (tick_zero && (bit_cnt_q == LAST_BIT)) state_d = RX_STOP;
         RX_STOP:  if (tick_zero) state_d = RX_IDLE;
         default:  state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      complete  = 1'b0;
      if (en) begin
         unique case (state_q)
            RX_IDLE: begin
               if (start_edge) cnt_d = START_LOAD;
            end
            RX_START: begin
               if (!tick_zero) begin
                  cnt_d = cnt_q - CW'(1);
               end else if (!bit_val) begin
                  cnt_d     = BIT_LOAD;
                  bit_cnt_d = 3'd0;
               end
            end
            RX_DATA: begin
               if (!tick_zero) begin
                  cnt_d = cnt_q - CW'(1);
               end else begin
                  shift_d   = {bit_val, shift_q[SPART_DATA_BITS-1:1]};
                  cnt_d     = BIT_LOAD;
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            RX_STOP: begin
               if (!tick_zero) cnt_d = cnt_q - CW'(1);
               else complete = 1'b1;
            end
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Frame completion takes priority over a simultaneous bus acknowledge.
   always_comb begin
      data_d = data_q;
      rda_d  = rda_q;
      fe_d   = fe_q;
      oe_d   = oe_q;
      if (complete) begin
         data_d = shift_q;
         fe_d   = ~bit_val;
         rda_d  = 1'b1;
         if (rda_q && !bus.clr_rda) oe_d = 1'b1;
      end else if (bus.clr_rda) begin
         rda_d = 1'b0;
         oe_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         rda_q     <= 1'b0;
         fe_q      <= 1'b0;
         oe_q      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         rda_q     <= rda_d;
         fe_q      <= fe_d;
         oe_q      <= oe_d;
      end
   end

   assign bus.data = data_q;
   assign bus.rda  = rda_q;
   assign bus.fe   = fe_q;
   assign bus.oe   = oe_q;

endmodule
